// File: rtl/summator_pkg.sv
// Shared types and constants for the summator arbiter slice.
package summator_pkg;

  localparam int SUM_WIDTH = 17;
  localparam int SUM_NCLI  = 2;

  localparam int CLI_SQRT = 0;
  localparam int CLI_MULT = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWNED = 2'd1,
    BLOCK = 2'd2
  } sum_state_e;

endpackage

// File: rtl/summator_arbiter_if.sv
// Client/arbiter bus for the shared summator: requests and operands in, grant and sum out.
interface summator_arbiter_if
  import summator_pkg::*;
#(
  parameter int WIDTH = SUM_WIDTH,
  parameter int NCLI  = SUM_NCLI
);

  logic [NCLI-1:0]       req_i;
  logic [NCLI*WIDTH-1:0] opa_i;
  logic [NCLI*WIDTH-1:0] opb_i;
  logic [NCLI-1:0]       grant_o;
  logic [WIDTH-1:0]      result_o;
  logic                  busy_o;
  logic                  timeout_o;

  modport master (
    output req_i, opa_i, opb_i,
    input  grant_o, result_o, busy_o, timeout_o
  );

  modport slave (
    input  req_i, opa_i, opb_i,
    output grant_o, result_o, busy_o, timeout_o
  );

endinterface

// File: rtl/summator_arbiter_summator.sv
// The single shared WIDTH-bit adder; sum wraps modulo 2^WIDTH.
module summator
  import summator_pkg::*;
#(
  parameter int WIDTH = SUM_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = a + b;

endmodule

// File: rtl/summator_arbiter.sv
// Round-robin owner arbitration for the shared summator, with a hold watchdog
// that revokes and blocks a client holding its grant too long.
module summator_arbiter
  import summator_pkg::*;
#(
  parameter int WIDTH    = SUM_WIDTH,
  parameter int NCLI     = SUM_NCLI,
  parameter int MAX_HOLD = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  summator_arbiter_if.slave bus
);

  localparam int PW = $clog2(NCLI);
  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  sum_state_e       state_r, state_n_s;
  logic [NCLI-1:0]  grant_r, grant_n_s;
  logic [NCLI-1:0]  blocked_r, blocked_n_s;
  logic [NCLI-1:0]  elig_s;
  logic [PW-1:0]    ptr_r, ptr_n_s;
  logic [PW-1:0]    own_s, search_ptr_s, cand_s, win_s;
  logic             win_vld_s;
  logic [CW-1:0]    cnt_r, cnt_n_s;
  logic             timeout_r, timeout_n_s;
  logic [WIDTH-1:0] opa_sel_s, opb_sel_s, sum_s;

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] idx);
    if (idx == PW'(NCLI - 1)) begin
      return '0;
    end else begin
      return idx + PW'(1);
    end
  endfunction

  // A blocked client stays ineligible until it lowers its request.
  assign elig_s = bus.req_i & ~blocked_r;

  // Owner index from the one-hot grant.
  always_comb begin
    own_s = '0;
    for (int i = 0; i < NCLI; i++) begin
      if (grant_r[i]) begin
        own_s = PW'(i);
      end else begin
        own_s = own_s;
      end
    end
  end

  // On release the search starts just past the departing owner.
  always_comb begin
    if (state_r == OWNED && !bus.req_i[own_s]) begin
      search_ptr_s = next_idx(own_s);
    end else begin
      search_ptr_s = ptr_r;
    end
  end

  // Cyclic first-eligible search starting at search_ptr_s.
  always_comb begin
    win_vld_s = 1'b0;
    win_s     = '0;
    cand_s    = '0;
    for (int i = 0; i < NCLI; i++) begin
      if (int'(search_ptr_s) + i >= NCLI) begin
        cand_s = PW'(int'(search_ptr_s) + i - NCLI);
      end else begin
        cand_s = PW'(int'(search_ptr_s) + i);
      end
      if (!win_vld_s && elig_s[cand_s]) begin
        win_vld_s = 1'b1;
        win_s     = cand_s;
      end else begin
        win_vld_s = win_vld_s;
      end
    end
  end

  // Next-state logic: grant, release, watchdog revoke.
  always_comb begin
    grant_n_s   = grant_r;
    blocked_n_s = blocked_r & bus.req_i;
    ptr_n_s     = ptr_r;
    cnt_n_s     = cnt_r;
    timeout_n_s = timeout_r;
    case (state_r)
      OWNED: begin
        if (!bus.req_i[own_s]) begin
          ptr_n_s = next_idx(own_s);
          cnt_n_s = '0;
          if (win_vld_s) begin
            grant_n_s = NCLI'(1) << win_s;
          end else begin
            grant_n_s = '0;
          end
        end else if (MAX_HOLD != 0 && cnt_r == CW'(MAX_HOLD - 1)) begin
          grant_n_s   = '0;
          timeout_n_s = 1'b1;
          ptr_n_s     = next_idx(own_s);
          blocked_n_s = blocked_n_s | grant_r;
          cnt_n_s     = '0;
        end else begin
          cnt_n_s = (MAX_HOLD != 0) ? cnt_r + CW'(1) : '0;
        end
      end
      IDLE, BLOCK: begin
        cnt_n_s = '0;
        if (win_vld_s) begin
          grant_n_s = NCLI'(1) << win_s;
        end else begin
          grant_n_s = '0;
        end
      end
      default: begin
        grant_n_s = '0;
        cnt_n_s   = '0;
      end
    endcase
    if (grant_n_s != '0) begin
      state_n_s = OWNED;
    end else if (blocked_n_s != '0) begin
      state_n_s = BLOCK;
    end else begin
      state_n_s = IDLE;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r   <= IDLE;
      grant_r   <= '0;
      blocked_r <= '0;
      ptr_r     <= '0;
      cnt_r     <= '0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_n_s;
      grant_r   <= grant_n_s;
      blocked_r <= blocked_n_s;
      ptr_r     <= ptr_n_s;
      cnt_r     <= cnt_n_s;
      timeout_r <= timeout_n_s;
    end
  end

  // AND-OR operand mux; all-zero grant yields zero operands and a zero sum.
  always_comb begin
    opa_sel_s = '0;
    opb_sel_s = '0;
    for (int i = 0; i < NCLI; i++) begin
      opa_sel_s = opa_sel_s | (bus.opa_i[i*WIDTH +: WIDTH] & {WIDTH{grant_r[i]}});
      opb_sel_s = opb_sel_s | (bus.opb_i[i*WIDTH +: WIDTH] & {WIDTH{grant_r[i]}});
    end
  end

  summator #(.WIDTH(WIDTH)) u_summator (
    .a (opa_sel_s),
    .b (opb_sel_s),
    .y (sum_s)
  );

  assign bus.grant_o   = grant_r;
  assign bus.result_o  = sum_s;
  assign bus.busy_o    = (grant_r != '0);
  assign bus.timeout_o = timeout_r;

endmodule

// File: tb/tb_summator_arbiter.sv
// Directed and randomized checks of summator_arbiter against a cycle-level ownership model.
module tb_summator_arbiter;
  import summator_pkg::*;

  localparam int W    = SUM_WIDTH;
  localparam int N    = SUM_NCLI;
  localparam int MAXH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  summator_arbiter_if #(.WIDTH(W), .NCLI(N)) bus ();

  summator_arbiter #(.WIDTH(W), .NCLI(N), .MAX_HOLD(MAXH)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  int total  = 0;
  int passed = 0;

  logic [N-1:0] req_v;
  logic [W-1:0] opa_v [N];
  logic [W-1:0] opb_v [N];

  int m_owner, m_ptr, m_cnt;
  bit m_blk [N];
  bit m_to;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) begin
      passed++;
    end else begin
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive();
    bus.req_i = req_v;
    for (int k = 0; k < N; k++) begin
      bus.opa_i[k*W +: W] = opa_v[k];
      bus.opb_i[k*W +: W] = opb_v[k];
    end
  endtask

  function automatic int pick();
    for (int i = 0; i < N; i++) begin
      int k;
      k = (m_ptr + i) % N;
      if (req_v[k] && !m_blk[k]) return k;
    end
    return -1;
  endfunction

  task automatic mdl_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_cnt   = 0;
    m_to    = 1'b0;
    for (int k = 0; k < N; k++) m_blk[k] = 1'b0;
  endtask

  // One clock of ownership rules, applied to the requests the DUT sampled.
  task automatic mdl_clock();
    for (int k = 0; k < N; k++) if (!req_v[k]) m_blk[k] = 1'b0;
    if (m_owner >= 0) begin
      if (!req_v[m_owner]) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = pick();
        m_cnt   = 0;
      end else if (m_cnt == MAXH - 1) begin
        m_to           = 1'b1;
        m_blk[m_owner] = 1'b1;
        m_ptr          = (m_owner + 1) % N;
        m_owner        = -1;
        m_cnt          = 0;
      end else begin
        m_cnt++;
      end
    end else begin
      m_owner = pick();
      m_cnt   = 0;
    end
  endtask

  function automatic logic [31:0] exp_grant();
    return (m_owner < 0) ? 32'd0 : (32'd1 << m_owner);
  endfunction

  function automatic logic [31:0] exp_result();
    logic [W-1:0] s;
    if (m_owner < 0) return 32'd0;
    s = opa_v[m_owner] + opb_v[m_owner];
    return 32'(s);
  endfunction

  task automatic step(input string tag);
    @(posedge clk);
    if (rst_n) mdl_clock();
    #1;
    chk({tag, ".grant"},   32'(bus.grant_o),   exp_grant());
    chk({tag, ".busy"},    32'(bus.busy_o),    32'(m_owner >= 0));
    chk({tag, ".timeout"}, 32'(bus.timeout_o), 32'(m_to));
    chk({tag, ".result"},  32'(bus.result_o),  exp_result());
  endtask

  initial begin
    int exp_idx;
    rst_n = 1'b0;
    req_v = '0;
    for (int k = 0; k < N; k++) begin
      opa_v[k] = '0;
      opb_v[k] = '0;
    end
    drive();
    mdl_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.grant",   32'(bus.grant_o),   32'd0);
    chk("rst.busy",    32'(bus.busy_o),    32'd0);
    chk("rst.timeout", 32'(bus.timeout_o), 32'd0);
    chk("rst.result",  32'(bus.result_o),  32'd0);
    rst_n = 1'b1;

    // Single client, 100 + (-30)
    opa_v[0] = 17'd100;
    opb_v[0] = 17'h1FFE2;
    req_v = 2'b01; drive();
    step("single");
    chk("single.grant_c", 32'(bus.grant_o), 32'h1);
    chk("single.sum70",   32'(bus.result_o), 32'd70);
    step("single_hold");
    req_v = 2'b00; drive();
    step("single_rel");
    chk("single_rel.idle", 32'(bus.grant_o), 32'h0);

    // Bring pointer back to 0, then simultaneous requests and handover
    req_v = 2'b10; drive(); step("ptr_a");
    req_v = 2'b00; drive(); step("ptr_b");
    req_v = 2'b11; drive(); step("simul");
    chk("simul.c0_first", 32'(bus.grant_o), 32'h1);
    opa_v[1] = 17'd5;
    opb_v[1] = 17'd7;
    req_v = 2'b10; drive(); step("handover");
    chk("handover.no_gap", 32'(bus.grant_o), 32'h2);
    chk("handover.sum12",  32'(bus.result_o), 32'd12);
    req_v = 2'b00; drive(); step("handover_rel");

    // Modular wrap-around
    opa_v[0] = 17'h1FFFF;
    opb_v[0] = 17'h00001;
    req_v = 2'b01; drive(); step("wrap");
    chk("wrap.zero", 32'(bus.result_o), 32'd0);
    req_v = 2'b00; drive(); step("wrap_rel");

    // Fairness: owner hands off every cycle, grants must alternate
    req_v = 2'b11; drive(); step("rr_start");
    exp_idx = 1;
    for (int g = 0; g < 10; g++) begin
      chk($sformatf("rr_alt%0d", g), 32'(bus.grant_o), 32'd1 << exp_idx);
      req_v = N'(1 << (exp_idx ^ 1)); drive();
      step($sformatf("rr%0d", g));
      exp_idx = exp_idx ^ 1;
    end
    req_v = 2'b00; drive(); step("rr_end");

    // Watchdog: four granted cycles then revoke and block
    req_v = 2'b01; drive();
    for (int c = 0; c < MAXH; c++) begin
      step($sformatf("wd_hold%0d", c));
      chk($sformatf("wd_grant%0d", c), 32'(bus.grant_o), 32'h1);
    end
    step("wd_revoke");
    chk("wd_revoke.grant",   32'(bus.grant_o),   32'h0);
    chk("wd_revoke.timeout", 32'(bus.timeout_o), 32'h1);
    step("wd_blk0");
    step("wd_blk1");
    chk("wd_blocked", 32'(bus.grant_o), 32'h0);
    req_v = 2'b11; drive(); step("wd_other");
    chk("wd_other.c1", 32'(bus.grant_o), 32'h2);
    req_v = 2'b01; drive(); step("wd_still");
    chk("wd_still_blocked", 32'(bus.grant_o), 32'h0);
    req_v = 2'b00; drive(); step("wd_drop");
    req_v = 2'b01; drive(); step("wd_regrant");
    chk("wd_regrant.c0",  32'(bus.grant_o),   32'h1);
    chk("wd_sticky",      32'(bus.timeout_o), 32'h1);
    req_v = 2'b00; drive(); step("wd_end");

    // Randomized requests and operands
    for (int t = 0; t < 400; t++) begin
      for (int k = 0; k < N; k++) begin
        opa_v[k] = W'($urandom);
        opb_v[k] = W'($urandom);
        if ($urandom_range(3) == 0) req_v[k] = ~req_v[k];
      end
      drive();
      step("rand");
    end

    // Asynchronous reset between edges while client 1 owns the adder
    req_v = 2'b00; drive(); step("ar_idle0"); step("ar_idle1");
    req_v = 2'b10; drive(); step("ar_pre");
    chk("ar_pre.c1", 32'(bus.grant_o), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar.grant",  32'(bus.grant_o),  32'h0);
    chk("ar.busy",   32'(bus.busy_o),   32'h0);
    chk("ar.result", 32'(bus.result_o), 32'h0);
    mdl_reset();
    #1;
    rst_n = 1'b1;
    step("ar_after");
    chk("ar_after.c1", 32'(bus.grant_o), 32'h2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/summator_arbiter.md
Name: summator_arbiter

Overview:
- Responder end of the shared summator interface: owns the single WIDTH-bit adder and serves operand/result requests from NCLI arithmetic clients (client 0 = sqrt, client 1 = multiplier).
- Grants exclusive adder ownership to one client for the whole of that client's busy period, using round-robin selection.
- Muxes the owner's operands into the adder and broadcasts the sum.
- A hold watchdog revokes a grant that is held too long.

Parameters:
- WIDTH, 17, operand/result width (two's complement, wraps modulo 2^WIDTH)
- NCLI, 2, number of clients (2..8)
- MAX_HOLD, 64, maximum cycles one grant may last; 0 disables the watchdog

Ports:
- clk_i  in  1  clock, all state updates on posedge
- rst_i  in  1  reset, asynchronous, active-low
- req_i  in  NCLI  per-client request, level; a client holds it high for the whole operation (its busy_o)
- opa_i  in  NCLI*WIDTH  packed first operands; client k occupies bits [k*WIDTH +: WIDTH]
- opb_i  in  NCLI*WIDTH  packed second operands, same packing (clients pass negated values for subtraction)
- grant_o  out  NCLI  one-hot registered grant; all-zero when idle
- result_o  out  WIDTH  opa+opb of the granted client, combinational from registered grant and operands; 0 when idle
- busy_o  out  1  high while any grant is active
- timeout_o  out  1  sticky flag, set when the watchdog revokes a grant; cleared only by reset

Behaviour:
- Reset (rst_i=0, async): state=IDLE, grant_o=0, busy_o=0, timeout_o=0, rr pointer=0, hold counter=0. result_o therefore reads 0.
- States:
  - IDLE: no owner.
  - OWNED: one grant bit set.
  - BLOCK: revoked owner is waiting for its req to drop.
- Transitions:
  - IDLE -> OWNED when any req_i is high. Winner is the first set req at or after the rr pointer, cyclic search. grant_o rises the cycle after req is sampled, so minimum latency is 1 cycle.
  - OWNED, owner req still high, hold counter < MAX_HOLD-1: stay, counter increments.
  - OWNED, owner req low: release. The rr pointer becomes owner+1 mod NCLI. If another req is high in that same cycle, the grant moves directly to the next winner (searched from the new pointer) with no idle cycle. Otherwise go to IDLE.
  - OWNED, counter reaches MAX_HOLD-1 while req still high (MAX_HOLD != 0): revoke. grant_o=0, timeout_o<=1, pointer advances, go to BLOCK.
  - BLOCK: the revoked client cannot be re-granted until its req drops. Other requesters are granted normally; BLOCK is tracked as a per-client blocked bit, so the arbiter may return to OWNED for another client while the bit stays set. The blocked bit clears when that req goes low.
- Grant is never withdrawn on a non-owner req change. Simultaneous requests are resolved purely by rr order.
- The hold counter resets to 0 on every new grant.
- Arithmetic:
  - result_o = (opa_owner + opb_owner) mod 2^WIDTH.
  - No carry or overflow output.
  - Non-granted clients' operands are ignored.
- Clients must gate their state updates on their grant bit. The arbiter does not check that.
- req dropping and rising in the same client across consecutive cycles is treated as a new request and follows rr order.
- An asynchronous reset mid-operation drops the grant immediately; the client sees result_o=0.

Decomposition:
- Package summator_pkg holds:
  - localparams SUM_WIDTH=17 and SUM_NCLI=2;
  - state encoding IDLE/OWNED/BLOCK;
  - client index constants CLI_SQRT=0 and CLI_MULT=1.
- One sub-module, summator: purely combinational WIDTH-bit adder (a, b -> a+b). It is instantiated once and fed by the owner mux.
- The rr search and the watchdog live in summator_arbiter.

Test Plan:
- Single client: from reset, req_i=01, opa0=100, opb0=-30 -> grant_o=01 one cycle later, result_o=70. req drops -> grant_o=00 and busy_o=0 next cycle, pointer=1.
- Simultaneous requests: req_i=11 at pointer 0 -> client 0 granted first. Client 0 drops while client 1 still requests -> grant_o goes 01->10 with no zero cycle. Client 1 operands 5 and 7 -> result_o=12.
- Round-robin fairness: both clients toggle req continuously over 10 grants -> grants strictly alternate 0,1,0,1.
- Wrap-around: opa=0x1FFFF, opb=0x00001 -> result_o=0x00000.
- Watchdog: MAX_HOLD=4, client 0 holds req -> grant revoked after 4 granted cycles and timeout_o=1 (sticky). Client 0 not re-granted until req toggles low; client 1 can still be granted.
- Async reset mid-grant: rst_i low between clock edges while grant_o=10 -> grant_o, busy_o and result_o are 0 immediately. After release, req_i=10 -> granted again in 1 cycle.
